window_averager: RTL and testbench

Parametrised sliding-window averager with peak tracking for the receive amplitude path. On each `next` strobe it takes one unsigned `amplitude` sample into a circular buffer of 2^LOG2_DEPTH entries and keeps a running sum. It outputs the windowed mean, a peak value, a per-update valid pulse and a window-full flag. It generalises the fixed single-sample averager with configurable width and depth, an explicit clear, and an optional peak-decay mode.

---
 rtl/window_averager.sv | 122 ++++++++++++
 tb/tb_window_averager.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/window_averager.sv
// ============================================================================
// Module   : window_averager
// Purpose  : Sliding-window mean over 2^LOG2_DEPTH samples with peak tracking;
//            optional peak decay enabled by defining AVERAGER_PEAK_DECAY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module window_averager #(
  parameter int WIDTH       = 16,
  parameter int LOG2_DEPTH  = 4,
  parameter int DECAY_SHIFT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] amplitude,
  input  logic             next,
  input  logic             clear,
  output logic [WIDTH-1:0] average,
  output logic [WIDTH-1:0] max_val,
  output logic             avg_valid,
  output logic             full
);

  localparam int c_depth = 1 << LOG2_DEPTH;
  localparam int c_sum_w = WIDTH + LOG2_DEPTH;
  localparam int c_cnt_w = LOG2_DEPTH + 1;

  localparam logic [1:0] c_st_empty   = 2'd0;
  localparam logic [1:0] c_st_filling = 2'd1;
  localparam logic [1:0] c_st_full    = 2'd2;

  logic [WIDTH-1:0]      r_buf [c_depth];
  logic [LOG2_DEPTH-1:0] r_wr_ptr;
  logic [c_sum_w-1:0]    r_sum;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [1:0]            r_state;
  logic [WIDTH-1:0]      r_avg;
  logic [WIDTH-1:0]      r_max;
  logic                  r_valid;

  logic                  w_accept;
  logic                  w_flush;
  logic [WIDTH-1:0]      w_oldest;
  logic [c_sum_w-1:0]    w_sum_next;
  logic [c_cnt_w-1:0]    w_cnt_next;
  logic [WIDTH-1:0]      w_peak_next;

  assign w_accept   = next & ~clear;
  assign w_flush    = ~rst_n | clear;
  assign w_oldest   = r_buf[r_wr_ptr];
  // The buffer starts zeroed, so subtracting the overwritten entry is always
  // correct, including while the window is still filling.
  assign w_sum_next = r_sum + c_sum_w'(amplitude) - c_sum_w'(w_oldest);
  assign w_cnt_next = (r_cnt == c_cnt_w'(c_depth)) ? r_cnt : r_cnt + 1'b1;

`ifdef AVERAGER_PEAK_DECAY_EN
  logic [WIDTH-1:0] w_decayed;
  assign w_decayed = r_max - (r_max >> DECAY_SHIFT);

  always_comb begin
    w_peak_next = r_max;
    if (amplitude > r_max) begin
      w_peak_next = amplitude;
    end else if (amplitude > w_decayed) begin
      w_peak_next = amplitude;
    end else begin
      w_peak_next = w_decayed;
    end
  end
`else
  logic w_unused_decay_shift;
  assign w_unused_decay_shift = (DECAY_SHIFT != 0);

  always_comb begin
    w_peak_next = r_max;
    if (amplitude > r_max) begin
      w_peak_next = amplitude;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (w_flush) begin
      for (int i = 0; i < c_depth; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_accept) begin
      r_buf[r_wr_ptr] <= amplitude;
    end
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_wr_ptr <= '0;
      r_sum    <= '0;
      r_cnt    <= '0;
      r_state  <= c_st_empty;
      r_avg    <= '0;
      r_max    <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_sum    <= w_sum_next;
        r_cnt    <= w_cnt_next;
        r_avg    <= w_sum_next[c_sum_w-1:LOG2_DEPTH];
        r_max    <= w_peak_next;
        r_state  <= (w_cnt_next == c_cnt_w'(c_depth)) ? c_st_full : c_st_filling;
      end
    end
  end

  assign average   = r_avg;
  assign max_val   = r_max;
  assign avg_valid = r_valid;
  assign full      = (r_state == c_st_full);

endmodule

`default_nettype wire

// File: tb/tb_window_averager.sv
// ============================================================================
// Module   : tb_window_averager
// Purpose  : Randomised and directed bench for window_averager (WIDTH=16, DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_window_averager;

  localparam int WIDTH       = 16;
  localparam int LOG2_DEPTH  = 2;
  localparam int DECAY_SHIFT = 4;
  localparam int DEPTH       = 1 << LOG2_DEPTH;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] amplitude = '0;
  logic             next = 1'b0;
  logic             clear = 1'b0;
  logic [WIDTH-1:0] average;
  logic [WIDTH-1:0] max_val;
  logic             avg_valid;
  logic             full;

  int checks = 0;
  int errors = 0;

  window_averager #(
    .WIDTH      (WIDTH),
    .LOG2_DEPTH (LOG2_DEPTH),
    .DECAY_SHIFT(DECAY_SHIFT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .amplitude(amplitude),
    .next     (next),
    .clear    (clear),
    .average  (average),
    .max_val  (max_val),
    .avg_valid(avg_valid),
    .full     (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: the window is simply the last DEPTH accepted samples.
  int unsigned hist [DEPTH];
  int unsigned m_avg, m_max, m_cnt;
  bit          m_valid;
  bit          model_ready = 0;

  always @(posedge clk) begin
    int unsigned s;
    int unsigned dec;
    if (!rst_n || clear) begin
      for (int i = 0; i < DEPTH; i++) hist[i] = 0;
      m_avg = 0; m_max = 0; m_cnt = 0; m_valid = 0;
      model_ready = 1;
    end else if (next) begin
      for (int i = DEPTH - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = amplitude;
      s = 0;
      for (int i = 0; i < DEPTH; i++) s += hist[i];
      m_avg = s / DEPTH;
      if (amplitude > m_max) begin
        m_max = amplitude;
      end else begin
`ifdef AVERAGER_PEAK_DECAY_EN
        dec   = m_max - (m_max >> DECAY_SHIFT);
        m_max = (amplitude > dec) ? amplitude : dec;
`else
        dec   = m_max;
        m_max = dec;
`endif
      end
      if (m_cnt < DEPTH) m_cnt++;
      m_valid = 1;
    end else begin
      m_valid = 0;
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      check("model_average", average, m_avg);
      check("model_max_val", max_val, m_max);
      check("model_full", full, (m_cnt == DEPTH) ? 1 : 0);
      check("model_avg_valid", avg_valid, m_valid);
    end
  end

  task automatic strobe(input int amp);
    @(posedge clk); #1;
    next = 1'b1; amplitude = WIDTH'(amp);
    @(posedge clk); #1;
    next = 1'b0; amplitude = WIDTH'($urandom);
  endtask

  task automatic do_clear();
    @(posedge clk); #1; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
  endtask

  initial begin
    int fill_exp [4];
    int step_exp [4];
    fill_exp = '{270, 540, 810, 1080};
    step_exp = '{1285, 1490, 1695, 1900};

    repeat (3) @(posedge clk);
    #1;
    check("reset_average", average, 0);
    check("reset_max_val", max_val, 0);
    check("reset_full", full, 0);
    check("reset_avg_valid", avg_valid, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      strobe(1080);
      check("fill_average", average, fill_exp[i]);
      check("fill_avg_valid", avg_valid, 1);
      check("fill_full", full, (i == 3) ? 1 : 0);
      @(posedge clk); #1;
      check("fill_valid_pulse", avg_valid, 0);
    end

    for (int i = 0; i < 4; i++) begin
      strobe(1900);
      check("step_average", average, step_exp[i]);
    end
    repeat (4) strobe(1960);
    check("converge_average", average, 1960);
    check("converge_max_val", max_val, 1960);

    strobe(190);
`ifdef AVERAGER_PEAK_DECAY_EN
    check("decay_max_1", max_val, 1838);
`else
    check("decay_max_1", max_val, 1960);
`endif
    strobe(190);
`ifdef AVERAGER_PEAK_DECAY_EN
    check("decay_max_2", max_val, 1724);
`else
    check("decay_max_2", max_val, 1960);
`endif

    @(posedge clk); #1;
    clear = 1'b1; next = 1'b1; amplitude = 16'd500;
    @(posedge clk); #1;
    clear = 1'b0; next = 1'b0;
    check("collide_average", average, 0);
    check("collide_max_val", max_val, 0);
    check("collide_full", full, 0);
    check("collide_avg_valid", avg_valid, 0);
    strobe(500);
    check("after_clear_average", average, 125);

    do_clear();
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      next = 1'b1; amplitude = (i % 2 == 0) ? 16'd190 : 16'd196;
      @(posedge clk); #1;
    end
    next = 1'b0;
    check("wrap_average", average, 193);
    check("wrap_max_val", max_val, 196);
    check("wrap_full", full, 1);

    do_clear();
    strobe(1080);
    strobe(1080);
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    check("midreset_average", average, 0);
    check("midreset_max_val", max_val, 0);
    check("midreset_full", full, 0);
    strobe(400);
    check("midreset_first_average", average, 100);
    check("midreset_first_full", full, 0);

    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      next      = ($urandom_range(0, 99) < 60);
      amplitude = ($urandom_range(0, 3) == 0) ? 16'hFFFF : WIDTH'($urandom);
      clear     = ($urandom_range(0, 99) < 3);
      rst_n     = !($urandom_range(0, 199) < 2);
    end
    @(posedge clk); #1;
    next = 1'b0; clear = 1'b0; rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
